tdc_event_collector: RTL and testbench
======================================

Name: tdc_event_collector

Overview:
Multi-channel result collector for N_CH TDC instances. Captures each channel's finished measurement (result word plus done pulse), tags it with channel index and a free-running capture timestamp, arbitrates round-robin into a shared FIFO, and presents records through a valid/ready stream to readout logic. It extends the single-channel TDC with channel count, buffering, single-shot/continuous modes and loss accounting.

Parameters:
N_CH, 4, number of TDC channels (1..16); CH_W = max(1, clog2(N_CH)) is derived.
DIG_W, 24, width of each channel's TDC result word.
TS_W, 16, width of the free-running capture timestamp.
DEPTH, 16, FIFO depth in records (power of 2, >= 2).
DROP_W, 8, width of the saturating drop counter.

Ports:
clk  in  1  single clock, all logic rising-edge.
iRst_n  in  1  asynchronous active-low reset.
iEnable  in  1  capture enable; when low, iDone is ignored (not counted as drop).
iMode  in  1  0 = continuous, 1 = single-shot (one capture per channel per arm).
iArm  in  1  single-cycle pulse; re-arms all channels in single-shot mode.
iFlush  in  1  synchronous clear of FIFO, pending registers and drop counter.
iDone  in  N_CH  per-channel one-cycle "result valid" pulses.
iTDC  in  N_CH*DIG_W  channel results; channel k at bits [k*DIG_W +: DIG_W].
oData  out  CH_W+TS_W+DIG_W  record {channel, timestamp, result}, MSB first.
oValid  out  1  oData valid (first-word-fall-through).
iReady  in  1  consumer accepts when oValid & iReady at a rising edge.
oLevel  out  clog2(DEPTH)+1  current FIFO occupancy.
oDrop  out  DROP_W  saturating count of lost captures.
oArmed  out  N_CH  per-channel armed status.

Behaviour:
- Reset (iRst_n low, async): FIFO empty, oValid=0, oData=0, oLevel=0, oDrop=0, all pending=0, timestamp=0, round-robin pointer=N_CH-1 (channel 0 searched first), oArmed=all ones.
- Timestamp: TS_W counter +1 every cycle, wraps 2^TS_W-1 -> 0; not cleared by iFlush.
- Capture: at an edge where iEnable & iDone[k] & oArmed[k]: pending[k] set, result and current timestamp latched into channel k holding register.
- Already-pending channel: if pending[k] and not granted this cycle, new capture is dropped (holding unchanged), oDrop +1 (saturates at all ones). If pending[k] is granted in the same cycle, new capture is accepted and pending[k] stays set; no drop.
- Multiple channels dropping the same cycle: oDrop increments by 1 per cycle (not per channel).
- Single-shot: capture clears oArmed[k]; iDone on a disarmed channel is ignored, not counted. iArm sets all oArmed the next edge; iArm coincident with iDone[k] on a disarmed channel: not captured. Continuous: oArmed held all ones.
- Arbiter: among pending channels, grant the first found searching from pointer+1 upward with wrap; at most one grant per cycle; grant only if FIFO not full (registered occupancy < DEPTH). Grant writes {k, ts_k, result_k}, clears pending[k] (unless recaptured), pointer := k.
- Latency: iDone sampled at edge E0 -> pending after E0 -> written at E1 (if granted) -> oValid=1 after E1. Minimum 2 cycles iDone to oValid.
- FIFO: simultaneous write and read allowed whenever not full; full blocks writes even if a read occurs that cycle. Empty: oValid=0, oData holds last value. Read of empty has no effect.
- iFlush: next edge empties FIFO, clears pending and oDrop, resets pointer; iDone in the flush cycle is discarded; oArmed unchanged. iFlush has priority over all writes/reads.
- Reset mid-operation: all state returns to reset values immediately; no partial record ever appears on oData with oValid=1.

Test Plan:
- N_CH=4, continuous, iDone[2] pulse with iTDC ch2=24'h00ABCD at timestamp 0x0010 -> oValid 2 cycles later, oData={2'd2,16'h0010,24'h00ABCD}, oLevel=1, no drop.
- iDone[0..3] all pulse same cycle, iReady=1 -> four records out in order ch0,1,2,3 on consecutive cycles; repeat with pointer left at 1 -> order 2,3,0,1.
- iReady=0, 17 captures on ch1 spaced 2 cycles -> oLevel saturates at 16, one pending held, subsequent captures increment oDrop; releasing iReady drains 17 records, oDrop equals lost count.
- iMode=1: two iDone[3] pulses -> one record, oArmed[3]=0, second ignored, oDrop=0; iArm then iDone[3] -> second record.
- iDone[1] while pending[1] granted same cycle -> both records emitted, oDrop=0; iDone[1] twice with FIFO full -> oDrop=1.
- Assert iRst_n low while oLevel=5 and pending set -> oValid=0, oLevel=0, oDrop=0 immediately; iFlush with level 3 -> oLevel=0 next cycle.

Source files
------------

// File: rtl/tdc_event_collector.sv
// tdc_event_collector
// Collects finished measurements from N_CH TDC channels. Each capture is
// tagged with its channel index and a free-running timestamp, held per
// channel, then moved round-robin into a shared FIFO. The FIFO is read out
// through a first-word-fall-through valid/ready stream. Captures lost to a
// busy channel are counted in a saturating drop counter.
module tdc_event_collector #(
  parameter int  N_CH   = 4,
  parameter int  DIG_W  = 24,
  parameter int  TS_W   = 16,
  parameter int  DEPTH  = 16,
  parameter int  DROP_W = 8,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int LVL_W  = $clog2(DEPTH) + 1,
  localparam int REC_W  = CH_W + TS_W + DIG_W
) (
  input  logic                    clk,
  input  logic                    iRst_n,
  input  logic                    iEnable,
  input  logic                    iMode,
  input  logic                    iArm,
  input  logic                    iFlush,
  input  logic [N_CH-1:0]         iDone,
  input  logic [N_CH*DIG_W-1:0]   iTDC,
  output logic [REC_W-1:0]        oData,
  output logic                    oValid,
  input  logic                    iReady,
  output logic [LVL_W-1:0]        oLevel,
  output logic [DROP_W-1:0]       oDrop,
  output logic [N_CH-1:0]         oArmed
);

  localparam int AW = $clog2(DEPTH);

  // Free-running capture timestamp
  logic [TS_W-1:0]   ts_reg;

  // Per-channel holding stage
  logic [N_CH-1:0]   pending_reg;
  logic [N_CH-1:0]   pending_next;
  logic [DIG_W-1:0]  res_hold_reg [N_CH];
  logic [TS_W-1:0]   ts_hold_reg  [N_CH];
  logic [N_CH-1:0]   armed_reg;
  logic [N_CH-1:0]   armed_next;

  // Per-channel decode of this cycle's events
  logic [N_CH-1:0]   attempt_vec;
  logic [N_CH-1:0]   accept_vec;
  logic [N_CH-1:0]   drop_vec;
  logic [N_CH-1:0]   granted_vec;

  // Round-robin arbiter
  logic [CH_W-1:0]   ptr_reg;
  logic              grant_found;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_en;
  logic [REC_W-1:0]  grant_rec;

  // Loss accounting
  logic [DROP_W-1:0] drop_reg;

  // Record FIFO
  logic [REC_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [LVL_W-1:0]  count_reg;
  logic [REC_W-1:0]  data_reg;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_en;
  logic              rd_en;

  assign fifo_full  = (count_reg == LVL_W'(DEPTH));
  assign fifo_empty = (count_reg == '0);

  // Timestamp counter; wraps naturally and is deliberately left running on flush
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      ts_reg <= '0;
    end else begin
      ts_reg <= ts_reg + 1'b1;
    end
  end

  // Round-robin search: first pending channel strictly after the last grant
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      if (!grant_found && pending_reg[(int'(ptr_reg) + i) % N_CH]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'((int'(ptr_reg) + i) % N_CH);
      end
    end
  end

  // A grant is only issued when the FIFO has room; flush suppresses everything
  assign grant_en  = grant_found && !fifo_full && !iFlush;
  assign grant_rec = {grant_idx, ts_hold_reg[grant_idx], res_hold_reg[grant_idx]};

  // Per-channel capture decode. A channel that is granted this cycle frees its
  // holding register, so a coincident capture is accepted instead of dropped.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign granted_vec[gi] = grant_en && (grant_idx == CH_W'(gi));
      assign attempt_vec[gi] = iEnable && iDone[gi] && armed_reg[gi] && !iFlush;
      assign accept_vec[gi]  = attempt_vec[gi] && (!pending_reg[gi] || granted_vec[gi]);
      assign drop_vec[gi]    = attempt_vec[gi] && pending_reg[gi] && !granted_vec[gi];
    end
  endgenerate

  // Pending flags: set by an accepted capture, cleared by a grant or a flush
  always_comb begin
    pending_next = pending_reg;
    if (iFlush) begin
      pending_next = '0;
    end else begin
      pending_next = (pending_reg & ~granted_vec) | accept_vec;
    end
  end

  // Arm state: continuous mode keeps every channel armed; single-shot
  // consumes the arm on any capture attempt until the next iArm pulse
  always_comb begin
    armed_next = armed_reg;
    if (iFlush) begin
      armed_next = armed_reg;
    end else if (!iMode) begin
      armed_next = '1;
    end else if (iArm) begin
      armed_next = '1;
    end else begin
      armed_next = armed_reg & ~attempt_vec;
    end
  end

  // Holding registers, pending flags and arm flags
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      pending_reg <= '0;
      armed_reg   <= '1;
      for (int k = 0; k < N_CH; k++) begin
        res_hold_reg[k] <= '0;
        ts_hold_reg[k]  <= '0;
      end
    end else begin
      pending_reg <= pending_next;
      armed_reg   <= armed_next;
      for (int k = 0; k < N_CH; k++) begin
        if (accept_vec[k]) begin
          res_hold_reg[k] <= iTDC[k*DIG_W +: DIG_W];
          ts_hold_reg[k]  <= ts_reg;
        end
      end
    end
  end

  // Arbiter pointer: remembers the last granted channel
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      ptr_reg <= CH_W'(N_CH - 1);
    end else if (iFlush) begin
      ptr_reg <= CH_W'(N_CH - 1);
    end else if (grant_en) begin
      ptr_reg <= grant_idx;
    end
  end

  // Drop counter: one step per cycle with any loss, saturating at all ones
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      drop_reg <= '0;
    end else if (iFlush) begin
      drop_reg <= '0;
    end else if ((|drop_vec) && (drop_reg != {DROP_W{1'b1}})) begin
      drop_reg <= drop_reg + 1'b1;
    end
  end

  assign wr_en = grant_en;
  assign rd_en = !fifo_empty && iReady && !iFlush;

  // FIFO storage array, write port only
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= grant_rec;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (iFlush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + LVL_W'(wr_en) - LVL_W'(rd_en);
    end
  end

  // Head-of-queue output register. A write into an empty (or emptying) FIFO
  // bypasses straight to the head; otherwise the next entry is read from the
  // array on a pop. With nothing to show, the last value is held.
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      data_reg <= '0;
    end else if (!iFlush) begin
      if (wr_en && (fifo_empty || (rd_en && (count_reg == LVL_W'(1))))) begin
        data_reg <= grant_rec;
      end else if (rd_en && (count_reg > LVL_W'(1))) begin
        data_reg <= mem[rd_ptr_reg + 1'b1];
      end
    end
  end

  assign oData  = data_reg;
  assign oValid = !fifo_empty;
  assign oLevel = count_reg;
  assign oDrop  = drop_reg;
  assign oArmed = armed_reg;

endmodule

// File: tb/tb_tdc_event_collector.sv
// tb_tdc_event_collector
// Directed scenarios followed by a randomized run. A queue-based reference
// model predicts every output after every clock edge.
module tb_tdc_event_collector;

  localparam int N_CH     = 4;
  localparam int DIG_W    = 24;
  localparam int TS_W     = 16;
  localparam int DEPTH    = 16;
  localparam int DROP_W   = 8;
  localparam int CH_W     = 2;
  localparam int REC_W    = CH_W + TS_W + DIG_W;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic                  clk = 1'b0;
  logic                  iRst_n;
  logic                  iEnable;
  logic                  iMode;
  logic                  iArm;
  logic                  iFlush;
  logic [N_CH-1:0]       iDone;
  logic [N_CH*DIG_W-1:0] iTDC;
  logic [REC_W-1:0]      oData;
  logic                  oValid;
  logic                  iReady;
  logic [4:0]            oLevel;
  logic [DROP_W-1:0]     oDrop;
  logic [N_CH-1:0]       oArmed;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0]      q[$];
  bit               m_pend [N_CH];
  logic [DIG_W-1:0] m_res  [N_CH];
  logic [TS_W-1:0]  m_ts   [N_CH];
  logic [N_CH-1:0]  m_arm;
  int               m_ptr;
  int               m_drop;
  int               m_tsc;
  logic [63:0]      m_last;
  int               got_ch[$];

  tdc_event_collector #(
    .N_CH(N_CH), .DIG_W(DIG_W), .TS_W(TS_W), .DEPTH(DEPTH), .DROP_W(DROP_W)
  ) dut (
    .clk(clk), .iRst_n(iRst_n), .iEnable(iEnable), .iMode(iMode), .iArm(iArm),
    .iFlush(iFlush), .iDone(iDone), .iTDC(iTDC), .oData(oData), .oValid(oValid),
    .iReady(iReady), .oLevel(oLevel), .oDrop(oDrop), .oArmed(oArmed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mkrec(int ch, logic [TS_W-1:0] ts, logic [DIG_W-1:0] r);
    return (64'(ch) << (TS_W + DIG_W)) | (64'(ts) << DIG_W) | 64'(r);
  endfunction

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < N_CH; k++) begin
      m_pend[k] = 1'b0;
      m_res[k]  = '0;
      m_ts[k]   = '0;
    end
    m_arm  = '1;
    m_ptr  = N_CH - 1;
    m_drop = 0;
    m_tsc  = 0;
    m_last = '0;
  endtask

  // One clock edge of the collector, described in terms of records moving
  // from channel slots into a queue and out to the consumer.
  task automatic model_edge();
    int g;
    bit dropped;
    logic [N_CH-1:0] att;
    att = '0;
    if (iFlush) begin
      q.delete();
      for (int k = 0; k < N_CH; k++) m_pend[k] = 1'b0;
      m_drop = 0;
      m_ptr  = N_CH - 1;
    end else begin
      g = -1;
      if (q.size() < DEPTH) begin
        for (int i = 1; i <= N_CH; i++) begin
          int k;
          k = (m_ptr + i) % N_CH;
          if (g < 0 && m_pend[k]) g = k;
        end
      end
      if (q.size() > 0 && iReady) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back(mkrec(g, m_ts[g], m_res[g]));
        m_pend[g] = 1'b0;
        m_ptr     = g;
      end
      dropped = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        if (iEnable && iDone[k] && m_arm[k]) begin
          att[k] = 1'b1;
          if (m_pend[k]) begin
            dropped = 1'b1;
          end else begin
            m_pend[k] = 1'b1;
            m_res[k]  = iTDC[k*DIG_W +: DIG_W];
            m_ts[k]   = TS_W'(m_tsc);
          end
        end
      end
      if (dropped && m_drop < DROP_MAX) m_drop++;
      if (!iMode || iArm) m_arm = '1;
      else m_arm = m_arm & ~att;
    end
    if (q.size() > 0) m_last = q[0];
    m_tsc = (m_tsc + 1) % (1 << TS_W);
  endtask

  task automatic cyc();
    if (oValid && iReady) got_ch.push_back(int'(oData[REC_W-1 -: CH_W]));
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", 64'(oValid), 64'(q.size() > 0));
    chk("level", 64'(oLevel), 64'(q.size()));
    chk("data",  64'(oData),  m_last);
    chk("drop",  64'(oDrop),  64'(m_drop));
    chk("armed", 64'(oArmed), 64'(m_arm));
  endtask

  task automatic rand_tdc();
    for (int k = 0; k < N_CH; k++) iTDC[k*DIG_W +: DIG_W] = DIG_W'($urandom());
  endtask

  task automatic pulse(input logic [N_CH-1:0] mask);
    iDone = mask;
    rand_tdc();
    cyc();
    iDone = '0;
  endtask

  task automatic gap(input int n);
    repeat (n) cyc();
  endtask

  task automatic flush();
    iFlush = 1'b1;
    cyc();
    iFlush = 1'b0;
  endtask

  task automatic hard_reset();
    #2 iRst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(oValid), 64'd0);
    chk("rst_level", 64'(oLevel), 64'd0);
    chk("rst_drop",  64'(oDrop),  64'd0);
    chk("rst_data",  64'(oData),  64'd0);
    chk("rst_armed", 64'(oArmed), 64'hF);
    model_reset();
    @(posedge clk);
    #1;
    iRst_n = 1'b1;
  endtask

  task automatic chk_order(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_cnt"}, 64'(got_ch.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_ch.size()) chk(tag, 64'(got_ch[i]), 64'(e[i]));
    end
  endtask

  initial begin
    iRst_n  = 1'b1;
    iEnable = 1'b0;
    iMode   = 1'b0;
    iArm    = 1'b0;
    iFlush  = 1'b0;
    iDone   = '0;
    iTDC    = '0;
    iReady  = 1'b0;
    model_reset();
    hard_reset();

    // First capture: channel 2 at timestamp 0x0010, consumer stalled
    iEnable = 1'b1;
    while (m_tsc != 16) cyc();
    iDone = 4'b0100;
    rand_tdc();
    iTDC[2*DIG_W +: DIG_W] = 24'h00ABCD;
    cyc();
    iDone = '0;
    chk("lat_e0_valid", 64'(oValid), 64'd0);
    cyc();
    chk("first_valid", 64'(oValid), 64'd1);
    chk("first_data",  64'(oData),  64'h0000_0200_1000_ABCD);
    chk("first_level", 64'(oLevel), 64'd1);
    chk("first_drop",  64'(oDrop),  64'd0);
    iReady = 1'b1;
    gap(2);

    // All channels at once, pointer freshly reset -> 0,1,2,3
    flush();
    got_ch.delete();
    pulse(4'hF);
    gap(6);
    chk_order("order_a", 0, 1, 2, 3);

    // Leave pointer at channel 1 -> 2,3,0,1
    flush();
    pulse(4'b0010);
    gap(3);
    got_ch.delete();
    pulse(4'hF);
    gap(6);
    chk_order("order_b", 2, 3, 0, 1);

    // Overflow: 20 captures on ch1 with consumer stalled
    flush();
    iReady = 1'b0;
    repeat (20) begin
      pulse(4'b0010);
      gap(1);
    end
    chk("ovf_level", 64'(oLevel), 64'd16);
    chk("ovf_drop",  64'(oDrop),  64'd3);
    got_ch.delete();
    iReady = 1'b1;
    gap(22);
    chk("ovf_drained", 64'(got_ch.size()), 64'd17);
    chk("ovf_drop_kept", 64'(oDrop), 64'd3);

    // Single-shot mode on channel 3
    flush();
    iReady = 1'b0;
    iMode  = 1'b1;
    pulse(4'b1000);
    gap(2);
    pulse(4'b1000);
    gap(2);
    chk("ss_level", 64'(oLevel), 64'd1);
    chk("ss_armed", 64'(oArmed), 64'h7);
    chk("ss_drop",  64'(oDrop),  64'd0);
    iArm  = 1'b1;
    iDone = 4'b1000;
    cyc();
    iArm  = 1'b0;
    iDone = '0;
    gap(2);
    chk("ss_arm_coinc_level", 64'(oLevel), 64'd1);
    chk("ss_rearmed", 64'(oArmed), 64'hF);
    pulse(4'b1000);
    gap(2);
    chk("ss_second_level", 64'(oLevel), 64'd2);
    iMode = 1'b0;
    cyc();

    // Recapture in the cycle the pending slot is granted
    flush();
    iReady = 1'b1;
    got_ch.delete();
    pulse(4'b0010);
    pulse(4'b0010);
    gap(4);
    chk("recap_count", 64'(got_ch.size()), 64'd2);
    chk("recap_drop",  64'(oDrop), 64'd0);

    // Two captures on ch1 with the FIFO full
    flush();
    iReady = 1'b0;
    repeat (16) begin
      pulse(4'b0001);
      gap(1);
    end
    chk("full_level", 64'(oLevel), 64'd16);
    pulse(4'b0010);
    gap(1);
    pulse(4'b0010);
    gap(1);
    chk("full_drop", 64'(oDrop), 64'd1);

    // Drop counter saturation
    iDone = 4'b0010;
    repeat (300) begin
      rand_tdc();
      cyc();
    end
    iDone = '0;
    chk("drop_sat", 64'(oDrop), 64'(DROP_MAX));

    // Reset mid-operation with level 5 and a pending channel
    flush();
    repeat (5) begin
      pulse(4'b0100);
      gap(1);
    end
    chk("pre_rst_level", 64'(oLevel), 64'd5);
    pulse(4'b1000);
    hard_reset();
    iEnable = 1'b1;
    repeat (3) begin
      pulse(4'b0001);
      gap(1);
    end
    chk("pre_flush_level", 64'(oLevel), 64'd3);
    flush();
    chk("flush_level", 64'(oLevel), 64'd0);
    chk("flush_valid", 64'(oValid), 64'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      iEnable = ($urandom_range(0, 9) != 0);
      if (((n / 150) % 2) == 0) iReady = ($urandom_range(0, 7) == 0);
      else iReady = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) iMode = ~iMode;
      iDone  = ($urandom_range(0, 2) == 0) ? N_CH'($urandom()) : '0;
      iArm   = (iDone == '0) && ($urandom_range(0, 7) == 0);
      iFlush = ($urandom_range(0, 119) == 0);
      rand_tdc();
      if (n == 400) hard_reset();
      cyc();
    end
    iDone  = '0;
    iArm   = 1'b0;
    iFlush = 1'b0;
    iReady = 1'b1;
    gap(24);
    chk("final_empty", 64'(oLevel), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
